// File: rtl/zeroriscy_mp_sram_pkg.sv
// Shared types and helpers for the multi-port banked SRAM model.
// Arbitration mode is chosen by MPSRAM_RR_ARB_EN (see zeroriscy_sram_bank_arb).
package zeroriscy_mp_sram_pkg;

    typedef enum logic [1:0] {
        REG_BOOT  = 2'd0,
        REG_INSTR = 2'd1,
        REG_DATA  = 2'd2
    } region_e;

    localparam logic [31:0] WIN_MASK = 32'hFFE0_0000;

    typedef struct packed {
        logic [10:0] tag;
        region_e     region;
        logic [16:0] index;
        logic [2:0]  bank;
        logic [16:0] row;
        logic [1:0]  offs;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] addr, input int lgb);
        dec_t d;
        d.tag    = addr[31:21];
        d.region = addr[20] ? REG_DATA : (addr[19] ? REG_INSTR : REG_BOOT);
        d.index  = addr[18:2];
        d.bank   = 3'(d.index & ((17'd1 << lgb) - 17'd1));
        d.row    = d.index >> lgb;
        d.offs   = addr[1:0];
        return d;
    endfunction

    function automatic logic [31:0] be2mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/zeroriscy_sram_bank_arb.sv
// Per-bank request arbiter: fixed lowest-index priority by default,
// round-robin with a per-bank pointer when MPSRAM_RR_ARB_EN is defined.
module zeroriscy_sram_bank_arb #(
    parameter int NPORTS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NPORTS-1:0] req,
    output logic [NPORTS-1:0] gnt
);

`ifdef MPSRAM_RR_ARB_EN
    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            k;

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NPORTS; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NPORTS) k = k - NPORTS;
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
                ptr_d  = (k == NPORTS - 1) ? '0 : PW'(k + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Isolate the lowest set request bit.
    assign gnt = req & (~req + NPORTS'(1));

    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: rtl/zeroriscy_mp_sram.sv
// Multi-port word-interleaved banked SRAM with per-bank arbitration.
// Define MPSRAM_RR_ARB_EN for round-robin instead of fixed-priority arbitration.
module zeroriscy_mp_sram
    import zeroriscy_mp_sram_pkg::*;
#(
    parameter int          NPORTS        = 2,
    parameter int          NBANKS        = 2,
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          BWORDS        = 4096,
    parameter int          IWORDS        = 4096,
    parameter int          DWORDS        = 32768,
    parameter bit          BOOT_WRITABLE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NPORTS-1:0]    req,
    input  logic [NPORTS-1:0]    we,
    input  logic [4*NPORTS-1:0]  be,
    input  logic [32*NPORTS-1:0] addr,
    input  logic [32*NPORTS-1:0] wdata,
    output logic [32*NPORTS-1:0] rdata,
    output logic [NPORTS-1:0]    gnt,
    output logic [NPORTS-1:0]    rvalid,
    output logic [NPORTS-1:0]    err
);

    localparam int LGB   = (NBANKS > 1) ? $clog2(NBANKS) : 0;
    localparam int BROWS = (BWORDS + NBANKS - 1) / NBANKS;
    localparam int IROWS = (IWORDS + NBANKS - 1) / NBANKS;
    localparam int DROWS = (DWORDS + NBANKS - 1) / NBANKS;
    localparam int BAW   = (BROWS > 1) ? $clog2(BROWS) : 1;
    localparam int IAW   = (IROWS > 1) ? $clog2(IROWS) : 1;
    localparam int DAW   = (DROWS > 1) ? $clog2(DROWS) : 1;

    localparam logic [17:0] BDEPTH = 18'(BWORDS);
    localparam logic [17:0] IDEPTH = 18'(IWORDS);
    localparam logic [17:0] DDEPTH = 18'(DWORDS);

    function automatic logic [17:0] depth_of(input region_e r);
        case (r)
            REG_BOOT:  return BDEPTH;
            REG_INSTR: return IDEPTH;
            default:   return DDEPTH;
        endcase
    endfunction

    dec_t [NPORTS-1:0]              dec;
    logic [NPORTS-1:0]              inwin;
    logic [NPORTS-1:0]              bad;
    logic [NBANKS-1:0][NPORTS-1:0]  breq;
    logic [NBANKS-1:0][NPORTS-1:0]  bgnt;
    logic [NBANKS-1:0][31:0]        bank_rd;
    logic [NPORTS-1:0][31:0]        prd;
    logic [NPORTS-1:0][31:0]        rdata_q;
    logic [NPORTS-1:0]              rvalid_q;
    logic [NPORTS-1:0]              err_q;

    always_comb begin
        dec   = '0;
        inwin = '0;
        bad   = '0;
        for (int p = 0; p < NPORTS; p++) begin
            dec[p]   = decode(addr[32*p +: 32], LGB);
            inwin[p] = (addr[32*p +: 32] & WIN_MASK) == (BASE_ADDR & WIN_MASK);
            bad[p]   = !inwin[p]
                     | ({1'b0, dec[p].index} >= depth_of(dec[p].region))
                     | (we[p] & (dec[p].region == REG_BOOT) & !BOOT_WRITABLE);
        end
    end

    always_comb begin
        breq = '0;
        for (int b = 0; b < NBANKS; b++) begin
            for (int p = 0; p < NPORTS; p++) begin
                breq[b][p] = req[p] & ~bad[p] & (dec[p].bank == 3'(b));
            end
        end
    end

    // Bad accesses bypass arbitration and are granted immediately.
    always_comb begin
        gnt = req & bad;
        for (int b = 0; b < NBANKS; b++) begin
            gnt = gnt | bgnt[b];
        end
    end

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [31:0] bmem [BROWS];
        logic [31:0] imem [IROWS];
        logic [31:0] dmem [DROWS];
        dec_t        sel;
        logic        act;
        logic        swe;
        logic [3:0]  sbe;
        logic [31:0] swd;
        logic [31:0] wmask;
        logic [31:0] rd;
        logic        unused_sel;

        zeroriscy_sram_bank_arb #(
            .NPORTS (NPORTS)
        ) u_arb (
            .clk (clk),
            .rst (rst),
            .req (breq[b]),
            .gnt (bgnt[b])
        );

        always_comb begin
            sel = '0;
            swe = 1'b0;
            sbe = '0;
            swd = '0;
            act = |bgnt[b];
            for (int p = 0; p < NPORTS; p++) begin
                if (bgnt[b][p]) begin
                    sel = dec[p];
                    swe = we[p];
                    sbe = be[4*p +: 4];
                    swd = wdata[32*p +: 32];
                end
            end
        end

        assign wmask      = be2mask(sbe);
        assign unused_sel = ^sel;

        always_comb begin
            rd = '0;
            case (sel.region)
                REG_BOOT:  rd = bmem[sel.row[BAW-1:0]];
                REG_INSTR: rd = imem[sel.row[IAW-1:0]];
                default:   rd = dmem[sel.row[DAW-1:0]];
            endcase
        end

        assign bank_rd[b] = rd;

        always_ff @(posedge clk) begin
            if (act && swe && !rst) begin
                case (sel.region)
                    REG_BOOT: bmem[sel.row[BAW-1:0]] <=
                        (bmem[sel.row[BAW-1:0]] & ~wmask) | (swd & wmask);
                    REG_INSTR: imem[sel.row[IAW-1:0]] <=
                        (imem[sel.row[IAW-1:0]] & ~wmask) | (swd & wmask);
                    default: dmem[sel.row[DAW-1:0]] <=
                        (dmem[sel.row[DAW-1:0]] & ~wmask) | (swd & wmask);
                endcase
            end
        end
    end

    always_comb begin
        prd = '0;
        for (int p = 0; p < NPORTS; p++) begin
            for (int b = 0; b < NBANKS; b++) begin
                if (dec[p].bank == 3'(b)) prd[p] = bank_rd[b];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= gnt;
            err_q    <= gnt & bad;
            for (int p = 0; p < NPORTS; p++) begin
                if (gnt[p]) begin
                    rdata_q[p] <= (bad[p] | we[p]) ? 32'h0 : prd[p];
                end
            end
        end
    end

    logic unused_dec;
    assign unused_dec = ^dec;

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_zeroriscy_mp_sram.sv
// Scoreboard bench for zeroriscy_mp_sram: random and directed traffic
// checked against a word-level memory and arbitration reference model.
module tb_zeroriscy_mp_sram;

    localparam int          NP    = 3;
    localparam int          NB    = 2;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          BW    = 4096;
    localparam int          IW    = 4096;
    localparam int          DW    = 32768;
    localparam bit          BOOTW = 1'b0;

    logic            clk;
    logic            rst;
    logic [NP-1:0]   req;
    logic [NP-1:0]   we;
    logic [4*NP-1:0] be;
    logic [32*NP-1:0] addr;
    logic [32*NP-1:0] wdata;
    logic [32*NP-1:0] rdata;
    logic [NP-1:0]   gnt;
    logic [NP-1:0]   rvalid;
    logic [NP-1:0]   err;

    zeroriscy_mp_sram #(
        .NPORTS        (NP),
        .NBANKS        (NB),
        .BASE_ADDR     (BASE),
        .BWORDS        (BW),
        .IWORDS        (IW),
        .DWORDS        (DW),
        .BOOT_WRITABLE (BOOTW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .be     (be),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic        chk;
        logic        err;
        logic [31:0] data;
        int          key;
    } exp_t;

    int checks = 0;
    int errors = 0;

    txn_t        sq [NP][$];
    exp_t        eq [NP][$];
    txn_t        cur [NP];
    bit          act [NP];
    bit          adv [NP];
    logic [31:0] mem [int];
    int          ptr [NB];
    logic [31:0] last_rd [NP];
    logic [31:0] pool [16];

    // Reference decode: window, region depth and read-only boot rules.
    function automatic bit model_bad(input txn_t t, output int key, output int bank);
        int rg;
        int idx;
        int depth;
        bit inwin;
        inwin = (t.addr >> 21) == (BASE >> 21);
        rg    = t.addr[20] ? 2 : (t.addr[19] ? 1 : 0);
        idx   = int'(t.addr[18:2]);
        depth = (rg == 0) ? BW : ((rg == 1) ? IW : DW);
        key   = rg * (1 << 17) + idx;
        bank  = idx % NB;
        return !inwin || idx >= depth || (t.we && rg == 0 && !BOOTW);
    endfunction

    function automatic txn_t mk(input bit w, input logic [3:0] b,
                                input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = w; t.be = b; t.addr = a; t.wdata = d;
        return t;
    endfunction

    task automatic push(input int p, input txn_t t);
        sq[p].push_back(t);
    endtask

    function automatic bit busy();
        for (int p = 0; p < NP; p++) begin
            if (act[p] || sq[p].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic drain(input int budget);
        int n;
        int left;
        n = 0;
        while (busy() && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        left = 0;
        for (int p = 0; p < NP; p++) left += eq[p].size();
        checks++;
        if (busy() || left != 0) begin
            errors++;
            $display("FAIL drain: busy=%0b pending_responses=%0d required 0", busy(), left);
        end
    endtask

    // Driver: holds each transaction until the model says it was granted.
    initial begin
        req = '0; we = '0; be = '0; addr = '0; wdata = '0;
        for (int p = 0; p < NP; p++) begin act[p] = 0; adv[p] = 0; end
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                if (act[p] && adv[p]) act[p] = 0;
                adv[p] = 0;
                if (!act[p] && sq[p].size() > 0) begin
                    cur[p] = sq[p].pop_front();
                    act[p] = 1;
                end
                req[p]           = act[p];
                we[p]            = act[p] & cur[p].we;
                be[4*p +: 4]     = cur[p].be;
                addr[32*p +: 32] = cur[p].addr;
                wdata[32*p +: 32] = cur[p].wdata;
            end
        end
    end

    // Reference model: expected grants, memory update, response queue.
    logic [NP-1:0] eg;
    bit            mbad [NP];
    int            mkey [NP];
    int            mbank [NP];
    exp_t          em;
    logic [31:0]   mm;
    int            wm;
    int            stm;
    int            pm;

    initial begin
        forever begin
            @(negedge clk);
            eg = '0;
            for (int p = 0; p < NP; p++) begin
                mbad[p] = 0;
                if (act[p]) begin
                    mbad[p] = model_bad(cur[p], mkey[p], mbank[p]);
                    if (mbad[p]) eg[p] = 1'b1;
                end
            end
            for (int b = 0; b < NB; b++) begin
                wm = -1;
`ifdef MPSRAM_RR_ARB_EN
                stm = ptr[b];
`else
                stm = 0;
`endif
                for (int i = 0; i < NP; i++) begin
                    pm = (stm + i) % NP;
                    if (wm < 0 && act[pm] && !mbad[pm] && mbank[pm] == b) wm = pm;
                end
                if (wm >= 0) begin
                    eg[wm] = 1'b1;
                    ptr[b] = (wm + 1) % NP;
                end
            end
            checks++;
            if (gnt !== eg) begin
                errors++;
                $display("FAIL gnt: got %b required %b at %0t", gnt, eg, $time);
            end
            if (rst) begin
                for (int p = 0; p < NP; p++) eq[p].delete();
                for (int b = 0; b < NB; b++) ptr[b] = 0;
            end else begin
                for (int p = 0; p < NP; p++) begin
                    if (eg[p]) begin
                        em.key  = mkey[p];
                        em.err  = mbad[p];
                        em.chk  = 1'b1;
                        em.data = '0;
                        if (!mbad[p]) begin
                            if (cur[p].we) begin
                                for (int i = 0; i < 4; i++) mm[8*i +: 8] = {8{cur[p].be[i]}};
                                if (mem.exists(mkey[p]))
                                    mem[mkey[p]] = (mem[mkey[p]] & ~mm) | (cur[p].wdata & mm);
                                else if (cur[p].be == 4'hF)
                                    mem[mkey[p]] = cur[p].wdata;
                            end else if (mem.exists(mkey[p])) begin
                                em.data = mem[mkey[p]];
                            end else begin
                                em.chk = 1'b0;
                            end
                        end
                        eq[p].push_back(em);
                    end
                end
            end
            for (int p = 0; p < NP; p++) adv[p] = eg[p];
        end
    end

    // Monitor: pops one expectation per rvalid and compares.
    exp_t        ex;
    logic [31:0] rdp;

    initial begin
        for (int p = 0; p < NP; p++) last_rd[p] = '0;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                rdp = rdata[32*p +: 32];
                checks++;
                if (rst) begin
                    last_rd[p] = '0;
                    if (rvalid[p] !== 1'b0 || err[p] !== 1'b0 || rdp !== '0) begin
                        errors++;
                        $display("FAIL reset_out p%0d: rvalid=%b err=%b rdata=%h required 0/0/0",
                                 p, rvalid[p], err[p], rdp);
                    end
                end else if (rvalid[p]) begin
                    if (eq[p].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_rvalid p%0d: rdata=%h err=%b at %0t",
                                 p, rdp, err[p], $time);
                    end else begin
                        ex = eq[p].pop_front();
                        if (err[p] !== ex.err || (ex.chk && rdp !== ex.data)) begin
                            errors++;
                            $display("FAIL resp p%0d: err=%b rdata=%h required err=%b rdata=%h at %0t",
                                     p, err[p], rdp, ex.err, ex.data, $time);
                        end
                        if (!ex.chk) begin
                            if (!mem.exists(ex.key)) mem[ex.key] = rdp;
                            last_rd[p] = rdp;
                        end else begin
                            last_rd[p] = ex.data;
                        end
                    end
                end else if (err[p] !== 1'b0 || rdp !== last_rd[p]) begin
                    errors++;
                    $display("FAIL idle_hold p%0d: err=%b rdata=%h required err=0 rdata=%h",
                             p, err[p], rdp, last_rd[p]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    logic [31:0] a;

    initial begin
        rst = 1'b1;
        for (int b = 0; b < NB; b++) ptr[b] = 0;
        for (int i = 0; i < 16; i++)
            pool[i] = ((i % 2) ? 32'h8008_0000 : 32'h8010_0000) + 32'(i * 4);
        pool[15] = 32'h8008_3FFC;
        pool[14] = 32'h8011_FFFC;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Write then read back
        push(0, mk(1, 4'hF, 32'h8010_0000, 32'hDEAD_BEEF));
        push(0, mk(0, 4'hF, 32'h8010_0000, 32'h0));
        drain(50);

        // Byte enables
        push(0, mk(1, 4'hF, 32'h8010_0100, 32'h1122_3344));
        push(0, mk(1, 4'h5, 32'h8010_0100, 32'hAABB_CCDD));
        push(0, mk(0, 4'hF, 32'h8010_0100, 32'h0));
        push(0, mk(1, 4'h0, 32'h8010_0100, 32'hFFFF_FFFF));
        push(0, mk(0, 4'hF, 32'h8010_0100, 32'h0));
        drain(50);

        // Same-bank conflict, then different banks, then aliases
        push(0, mk(1, 4'hF, 32'h8010_0008, 32'h0000_0008));
        push(0, mk(1, 4'hF, 32'h8010_0010, 32'h0000_0010));
        push(0, mk(1, 4'hF, 32'h8010_0004, 32'h0000_0004));
        drain(50);
        for (int r = 0; r < 2; r++) begin
            push(0, mk(0, 4'hF, 32'h8010_0000, 32'h0));
            push(1, mk(0, 4'hF, 32'h8010_0008, 32'h0));
            push(2, mk(0, 4'hF, 32'h8010_0010, 32'h0));
        end
        drain(50);
        push(0, mk(0, 4'hF, 32'h8010_0000, 32'h0));
        push(1, mk(0, 4'hF, 32'h8010_0004, 32'h0));
        push(2, mk(0, 4'hF, 32'h8018_0008, 32'h0));
        drain(50);

        // Error cases
        push(0, mk(0, 4'hF, 32'h9000_0000, 32'h0));
        push(1, mk(0, 4'hF, 32'h8000_0000, 32'h0));
        drain(50);
        push(1, mk(1, 4'hF, 32'h8000_0000, 32'h1234_5678));
        push(1, mk(0, 4'hF, 32'h8000_0000, 32'h0));
        push(2, mk(0, 4'hF, 32'h8008_4000, 32'h0));
        push(0, mk(0, 4'hF, 32'h8012_0000, 32'h0));
        push(0, mk(1, 4'hF, 32'h8012_0000, 32'h5555_5555));
        drain(50);

        // Random traffic over a pre-initialised pool
        for (int i = 0; i < 16; i++) push(i % NP, mk(1, 4'hF, pool[i], $urandom));
        drain(200);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            for (int p = 0; p < NP; p++) begin
                if (sq[p].size() < 2 && $urandom_range(0, 2) != 0) begin
                    a = pool[$urandom_range(0, 15)];
                    if ($urandom_range(0, 9) == 0) begin
                        case ($urandom_range(0, 3))
                            0: a = 32'h9000_0000 | ($urandom & 32'h000F_FFFC);
                            1: a = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4);
                            2: a = 32'h8008_4000 + 32'($urandom_range(0, 100) * 4);
                            default: a = 32'h8012_0000;
                        endcase
                    end
                    push(p, mk($urandom_range(0, 1) == 1, 4'($urandom), a, $urandom));
                end
            end
        end
        drain(3000);

        // Reset while p0 has a response pending and another grant in flight
        @(negedge clk);
        push(0, mk(0, 4'hF, pool[0], 32'h0));
        push(0, mk(0, 4'hF, pool[2], 32'h0));
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (rvalid !== '0 || err !== '0 || rdata !== '0) begin
            errors++;
            $display("FAIL async_reset: rvalid=%b err=%b rdata=%h required all zero",
                     rvalid, err, rdata);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        drain(50);

        // Arbitration restarts after reset
        for (int r = 0; r < 2; r++) begin
            push(0, mk(0, 4'hF, 32'h8010_0000, 32'h0));
            push(1, mk(0, 4'hF, 32'h8010_0008, 32'h0));
            push(2, mk(0, 4'hF, 32'h8010_0010, 32'h0));
        end
        drain(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zeroriscy_mp_sram.md
Name: zeroriscy_mp_sram

Overview:
Parametrised multi-port, word-interleaved banked SRAM model for the zero-riscy test environment. It is the successor to the fixed dual-port boot/instruction/data memory. It serves NPORTS OBI-style request/grant ports, one per core fetch or LSU master. Each bank is single-access per cycle and has its own arbiter, so `gnt` can stall on a bank conflict. Out-of-window, out-of-region and ROM-write accesses complete with an error response.

Parameters:
NPORTS, 2, number of request ports (1..8)
NBANKS, 2, word-interleaved banks, power of two (1..8)
BASE_ADDR, 32'h8000_0000, 2 MB window base; only bits [31:21] are compared
BWORDS, 4096, boot region depth in words (addr[20:19]=00)
IWORDS, 4096, instruction region depth in words (addr[20:19]=01)
DWORDS, 32768, data region depth in words (addr[20:19]=1x)
BOOT_WRITABLE, 1, 0 makes the boot region read-only

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req  in  NPORTS  per-port request
we  in  NPORTS  per-port write enable
be  in  4*NPORTS  byte enables, port p at [4p+3:4p]
addr  in  32*NPORTS  byte address, port p at [32p+31:32p]
wdata  in  32*NPORTS  write data
rdata  out  32*NPORTS  read data, valid when rvalid
gnt  out  NPORTS  grant, combinational, same cycle as req
rvalid  out  NPORTS  response valid, one cycle after gnt
err  out  NPORTS  error flag, qualified by rvalid

Behaviour:
- Reset (async, rst=1): rvalid=0, err=0, rdata=0, all round-robin pointers=0. Memory contents are not reset. A grant in the reset cycle produces no response.
- Decode, per port:
  - inwin = addr[31:21]==BASE_ADDR[31:21].
  - Region from addr[20:19]. Word index = addr[18:2].
  - Bank = index[log2(NBANKS)-1:0]. Row = index>>log2(NBANKS).
  - bad = !inwin | index>=region depth | (we & boot region & !BOOT_WRITABLE).
- Bad access: gnt=req with no arbitration. Next cycle rvalid=1, err=1, rdata=0. Memory is untouched.
- Good access: competes for its target bank.
  - Per bank, the winner is the lowest-index requesting port (fixed priority).
  - gnt[p] = req[p] & winner. Losers see gnt=0 and must hold req/we/be/addr/wdata stable until granted.
- Granted write: bytes with be=1 are updated at the clk edge. be=0000 is a legal no-op write.
  - Next cycle rvalid=1, err=0, rdata=0.
- Granted read: next cycle rvalid=1, err=0, rdata = word contents before any write in the grant cycle. Only one access per bank per cycle, so there is no same-word RAW hazard.
- Back-to-back: a port may be granted every cycle, with throughput 1/cycle/port absent conflicts. rvalid follows each gnt by exactly 1 cycle.
- Ports hitting different banks are all granted in the same cycle.
- When rvalid=0, rdata holds its last value and err=0.
- Depth not divisible by NBANKS: the index>=depth check applies before banking, so partial rows are never addressed.

Optional Feature:
MPSRAM_RR_ARB_EN.
- Defined: each bank keeps a round-robin pointer (log2(NPORTS) bits, reset 0). The search for the winner starts at the pointer. On a grant, the pointer moves to winner+1 mod NPORTS. No port waits more than NPORTS-1 grant cycles.
- Undefined: fixed priority as above and no pointer registers.

Decomposition:
- Package zeroriscy_mp_sram_pkg:
  - region_e enum {REG_BOOT, REG_INSTR, REG_DATA}.
  - Window mask constant.
  - Function decode(addr) returning region, index, bank, row.
  - Byte-mask expansion function be2mask.
- Sub-module zeroriscy_sram_bank_arb, instantiated NBANKS times:
  - Inputs: NPORTS request vector, clk, rst.
  - Outputs: one-hot grant.
  - Holds the RR pointer under MPSRAM_RR_ARB_EN.
- Top level holds the per-region, per-bank arrays, the response registers and the error logic.

Test Plan:
1. NPORTS=2 NBANKS=2: p0 writes 0xDEADBEEF to 0x8010_0000 with be=1111, then reads it → gnt same cycle; read rvalid next cycle, rdata=0xDEADBEEF, err=0.
2. Byte enables: write 0x11223344, then write 0xAABBCCDD with be=0101, then read → 0x11BB33DD.
3. Conflict, NPORTS=3: p0, p1 and p2 read the same bank (0x8010_0000, 0x8010_0008, 0x8010_0010) in one cycle.
   - Without the macro: gnt=001, then 010, then 100, each followed by rvalid.
   - With MPSRAM_RR_ARB_EN and all three held 6 cycles: grant order p0,p1,p2,p0,p1,p2.
4. No conflict: p0 accesses 0x8010_0000 (bank0) and p1 accesses 0x8010_0004 (bank1) → both gnt=1 in the same cycle; both rvalid next cycle.
5. Errors:
   - Read 0x9000_0000 → gnt=1, then rvalid=1, err=1, rdata=0.
   - BOOT_WRITABLE=0, write 0x8000_0000 → err=1, and a later read returns the old value.
   - Instruction index 4096 (0x8008_4000) → err=1.
6. Assert rst while p0 is granted → rvalid=0, err=0 and rdata=0 immediately. No response appears after rst falls. The RR pointers restart at p0.
